// File: rtl/inv_sub_bytes_iter_pkg.sv
// Shared definitions for the iterative InvSubBytes stage: FSM encodings and AES state sizes.
package inv_sub_bytes_iter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int unsigned AES_STATE_W = 128;
    localparam int unsigned AES_NBYTES  = 16;

endpackage

// File: rtl/inv_sub_bytes_iter_sbox.sv
// InverseSbox: single-byte AES inverse S-box lookup, purely combinational.
module InverseSbox (
    input  logic [7:0] data_in,
    output logic [7:0] data_out
);

    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    assign data_out = INV_SBOX[data_in];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative InvSubBytes: substitutes the 16 state bytes SBOX_LANES at a time,
// then holds the result until the downstream stage accepts it.
module inv_sub_bytes_iter
    import inv_sub_bytes_iter_pkg::*;
#(
    parameter int unsigned SBOX_LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int unsigned NSTEP  = AES_NBYTES / SBOX_LANES;
    localparam int unsigned STEP_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;

    state_e                        state;
    state_e                        state_nxt;
    logic [STEP_W-1:0]             step;
    // Element 0 is the most significant byte, matching in_state byte numbering.
    logic [0:AES_NBYTES-1][7:0]    work;
    logic                          last_step;
    logic [3:0]                    lane_idx [SBOX_LANES];
    logic [7:0]                    lane_in  [SBOX_LANES];
    logic [7:0]                    lane_out [SBOX_LANES];

    assign last_step = (step == STEP_W'(NSTEP - 1));

    always_comb begin
        for (int unsigned l = 0; l < SBOX_LANES; l++) begin
            lane_idx[l] = 4'(32'(step) * SBOX_LANES + l);
            lane_in[l]  = work[lane_idx[l]];
        end
    end

    for (genvar g = 0; g < SBOX_LANES; g++) begin : g_lane
        InverseSbox u_sbox (
            .data_in  (lane_in[g]),
            .data_out (lane_out[g])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (in_valid)  state_nxt = ST_RUN;
            ST_RUN:  if (last_step) state_nxt = ST_HOLD;
            ST_HOLD: if (out_ready) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            step <= '0;
            work <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        work <= in_state;
                        step <= '0;
                    end
                end
                ST_RUN: begin
                    for (int unsigned l = 0; l < SBOX_LANES; l++) begin
                        work[lane_idx[l]] <= lane_out[l];
                    end
                    step <= last_step ? '0 : step + STEP_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_HOLD);
    assign busy      = (state != ST_IDLE);
    assign out_state = work;

endmodule
